// File: rtl/gol_fb_pkg.sv
// rtl/gol_fb_pkg.sv - framebuffer packing constants and frame writer state type
package gol_fb_pkg;
  localparam int PIX_W           = 4;
  localparam int PIX_PER_WORD    = 8;
  localparam int ADDR_W          = 9;
  localparam int WORDS_PER_FRAME = 512;
  localparam int WORD_W          = PIX_W * PIX_PER_WORD;
  localparam int SLOT_W          = $clog2(PIX_PER_WORD);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    FILL,
    WRITE,
    SWAP_WAIT
  } fw_state_t;
endpackage

// File: rtl/frame_writer_if.sv
// rtl/frame_writer_if.sv - pixel stream and memory write port bundles
interface fw_pix_if;
  logic                       s_valid;
  logic                       s_ready;
  logic [gol_fb_pkg::PIX_W-1:0] s_pixel;
  logic                       s_last;

  modport master (output s_valid, output s_pixel, output s_last, input s_ready);
  modport slave  (input s_valid, input s_pixel, input s_last, output s_ready);
endinterface

interface fw_mem_if;
  logic                          mem_req;
  logic                          mem_gnt;
  logic                          mem_bank;
  logic [gol_fb_pkg::ADDR_W-1:0] mem_addr;
  logic [gol_fb_pkg::WORD_W-1:0] mem_wdata;

  modport master (output mem_req, output mem_bank, output mem_addr, output mem_wdata, input mem_gnt);
  modport slave  (input mem_req, input mem_bank, input mem_addr, input mem_wdata, output mem_gnt);
endinterface

// File: rtl/frame_writer_word_packer.sv
// rtl/frame_writer_word_packer.sv - packs colour indices into nibble slots of one word
module frame_writer_word_packer
  import gol_fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              clear,
  input  logic [PIX_W-1:0]  pixel,
  output logic [WORD_W-1:0] word,
  output logic [SLOT_W-1:0] slot,
  output logic              word_full
);
  assign word_full = accept && (slot == LAST_SLOT);

  // Clearing on grant leaves untouched slots of a short final word at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      slot <= '0;
    end else if (accept) begin
      word[slot*PIX_W +: PIX_W] <= pixel;
      slot                      <= slot + SLOT_W'(1);
    end
  end
endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - packs a pixel stream into words and writes the back framebuffer bank
module frame_writer
  import gol_fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fw_pix_if.slave    pix,
  fw_mem_if.master   mem,
  input  logic       frame_end,
  output logic       disp_bank,
  output logic [7:0] frame_count,
  output logic       short_frame
);
  fw_state_t         state;
  logic              mem_req_q;
  logic              mem_bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_word_q;

  logic              accept;
  logic              granted;
  logic              swap;
  logic              frame_last_pix;
  logic              word_full;
  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] word;

  assign pix.s_ready    = (state == FILL) && !reset;
  assign accept         = pix.s_valid && pix.s_ready;
  assign granted        = (state == WRITE) && mem.mem_gnt;
  assign frame_last_pix = (addr_q == LAST_ADDR) && (slot == LAST_SLOT);
  // A frame_end landing on the final grant swaps without visiting SWAP_WAIT.
  assign swap           = frame_end && ((state == SWAP_WAIT) || (granted && last_word_q));

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_bank  = mem_bank_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = word;

  frame_writer_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .clear     (granted),
    .pixel     (pix.s_pixel),
    .word      (word),
    .slot      (slot),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      mem_req_q   <= 1'b0;
      mem_bank_q  <= 1'b1;
      disp_bank   <= 1'b0;
      addr_q      <= '0;
      last_word_q <= 1'b0;
      frame_count <= 8'd0;
      short_frame <= 1'b0;
    end else begin
      short_frame <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            short_frame <= pix.s_last && !frame_last_pix;
            if (word_full || pix.s_last) begin
              state       <= WRITE;
              mem_req_q   <= 1'b1;
              last_word_q <= pix.s_last || (addr_q == LAST_ADDR);
            end
          end
        end
        WRITE: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (last_word_q) begin
              state <= SWAP_WAIT;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              state  <= FILL;
            end
          end
        end
        SWAP_WAIT: ;
        default: state <= FILL;
      endcase

      if (swap) begin
        state       <= FILL;
        mem_bank_q  <= !mem_bank_q;
        disp_bank   <= mem_bank_q;
        addr_q      <= '0;
        frame_count <= frame_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - randomized self-checking bench for frame_writer
module tb_frame_writer;
  import gol_fb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       disp_bank;
  logic [7:0] frame_count;
  logic       short_frame;

  fw_pix_if pix ();
  fw_mem_if mem ();

  frame_writer dut (
    .clk         (clk),
    .reset       (reset),
    .pix         (pix),
    .mem         (mem),
    .frame_end   (frame_end),
    .disp_bank   (disp_bank),
    .frame_count (frame_count),
    .short_frame (short_frame)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          gnt_mode = 0;
  logic        gnt_manual = 1'b0;
  int          idle_en = 0;
  int          short_cnt = 0;
  int          exp_short = 0;
  logic        exp_bank = 1'b1;
  logic [7:0]  exp_count = 8'd0;
  logic [41:0] got_q[$];
  logic [41:0] exp_q[$];
  logic [3:0]  frame_px[$];
  logic [31:0] stall_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic abort(input string tag);
    check_val(tag, 64'd0, 64'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "bench stopped on timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0:       mem.mem_gnt = 1'b1;
      1:       mem.mem_gnt = ($urandom_range(0, 3) != 0);
      default: mem.mem_gnt = gnt_manual;
    endcase
  end

  always @(negedge clk) begin
    if (!reset && mem.mem_req && mem.mem_gnt)
      got_q.push_back({mem.mem_bank, mem.mem_addr, mem.mem_wdata});
    if (!reset && short_frame)
      short_cnt++;
  end

  task automatic push_pixel(input logic [3:0] pv, input logic last);
    int guard;
    if (idle_en != 0 && $urandom_range(0, 7) == 0) begin
      @(posedge clk); #1;
    end
    pix.s_valid = 1'b1;
    pix.s_pixel = pv;
    pix.s_last  = last;
    guard = 0;
    @(negedge clk);
    while (!pix.s_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) abort("s_ready_timeout");
    @(posedge clk); #1;
    pix.s_valid = 1'b0;
    pix.s_last  = 1'b0;
  endtask

  // Expected writes: word w holds pixels 8w..8w+7, pixel k of the word in bits [4k+3:4k].
  task automatic model_frame(input logic use_last);
    int n;
    n = frame_px.size();
    for (int w = 0; w * PIX_PER_WORD < n; w++) begin
      logic [31:0] d;
      d = 32'd0;
      for (int k = 0; k < PIX_PER_WORD; k++)
        if (w * PIX_PER_WORD + k < n) d[k*4 +: 4] = frame_px[w * PIX_PER_WORD + k];
      exp_q.push_back({exp_bank, 9'(w), d});
    end
    if (use_last && n < 4096) exp_short++;
  endtask

  task automatic send_frame(input logic use_last);
    model_frame(use_last);
    for (int i = 0; i < frame_px.size(); i++)
      push_pixel(frame_px[i], use_last && (i == frame_px.size() - 1));
  endtask

  task automatic rand_frame(input int n);
    frame_px.delete();
    for (int i = 0; i < n; i++) frame_px.push_back(4'($urandom));
  endtask

  task automatic wait_writes;
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_val("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val("write_word", 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic swap_check;
    @(negedge clk);
    check_val("swap_wait_ready", 64'(pix.s_ready), 64'd0);
    check_val("swap_wait_req", 64'(mem.mem_req), 64'd0);
    @(posedge clk); #1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    exp_bank  = !exp_bank;
    exp_count = exp_count + 8'd1;
    @(negedge clk);
    check_val("swap_mem_bank", 64'(mem.mem_bank), 64'(exp_bank));
    check_val("swap_disp_bank", 64'(disp_bank), 64'(!exp_bank));
    check_val("swap_frame_count", 64'(frame_count), 64'(exp_count));
    check_val("swap_addr", 64'(mem.mem_addr), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    pix.s_valid = 1'b0;
    pix.s_last  = 1'b0;
    frame_end   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_bank  = 1'b1;
    exp_count = 8'd0;
    short_cnt = 0;
    exp_short = 0;
  endtask

  initial begin
    pix.s_valid = 1'b0;
    pix.s_last  = 1'b0;
    pix.s_pixel = 4'd0;

    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_s_ready", 64'(pix.s_ready), 64'd0);
    check_val("rst_mem_req", 64'(mem.mem_req), 64'd0);
    check_val("rst_mem_bank", 64'(mem.mem_bank), 64'd1);
    check_val("rst_disp_bank", 64'(disp_bank), 64'd0);
    check_val("rst_mem_addr", 64'(mem.mem_addr), 64'd0);
    check_val("rst_mem_wdata", 64'(mem.mem_wdata), 64'd0);
    check_val("rst_frame_count", 64'(frame_count), 64'd0);
    check_val("rst_short_frame", 64'(short_frame), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_s_ready", 64'(pix.s_ready), 64'd1);
    @(posedge clk); #1;

    // single word, grant held high
    gnt_mode = 0;
    exp_q.push_back({1'b1, 9'd0, 32'h87654321});
    for (int i = 1; i <= 8; i++) push_pixel(4'(i), 1'b0);
    @(negedge clk);
    check_val("sw_req_on", 64'(mem.mem_req), 64'd1);
    check_val("sw_ready_off", 64'(pix.s_ready), 64'd0);
    check_val("sw_wdata", 64'(mem.mem_wdata), 64'h87654321);
    check_val("sw_addr", 64'(mem.mem_addr), 64'd0);
    check_val("sw_bank", 64'(mem.mem_bank), 64'd1);
    @(negedge clk);
    check_val("sw_req_off", 64'(mem.mem_req), 64'd0);
    check_val("sw_ready_on", 64'(pix.s_ready), 64'd1);
    wait_writes();

    // grant stall
    do_reset();
    gnt_mode = 2;
    gnt_manual = 1'b0;
    @(posedge clk); #1;
    rand_frame(8);
    send_frame(1'b0);
    stall_data = exp_q[0][31:0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall_req", 64'(mem.mem_req), 64'd1);
      check_val("stall_ready", 64'(pix.s_ready), 64'd0);
      check_val("stall_addr", 64'(mem.mem_addr), 64'd0);
      check_val("stall_wdata", 64'(mem.mem_wdata), 64'(stall_data));
      check_val("stall_no_write", 64'(got_q.size()), 64'd0);
    end
    gnt_manual = 1'b1;
    @(posedge clk); #2;
    gnt_manual = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("stall_addr_next", 64'(mem.mem_addr), 64'd1);
    wait_writes();

    // reset in the middle of a word
    do_reset();
    gnt_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_pixel(4'($urandom), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("midrst_ready", 64'(pix.s_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_no_write", 64'(got_q.size()), 64'd0);
    check_val("midrst_bank", 64'(mem.mem_bank), 64'd1);
    check_val("midrst_addr", 64'(mem.mem_addr), 64'd0);
    check_val("midrst_wdata", 64'(mem.mem_wdata), 64'd0);
    @(posedge clk); #1;
    rand_frame(8);
    send_frame(1'b0);
    wait_writes();

    // short frame: eleven pixels, the last is 0xF and carries s_last
    do_reset();
    frame_px.delete();
    for (int i = 0; i < 10; i++) frame_px.push_back(4'h1);
    frame_px.push_back(4'hF);
    model_frame(1'b1);
    for (int i = 0; i < 11; i++) push_pixel(frame_px[i], i == 10);
    @(negedge clk);
    check_val("short_pulse", 64'(short_frame), 64'd1);
    check_val("short_wdata", 64'(mem.mem_wdata), 64'h00000F11);
    check_val("short_addr", 64'(mem.mem_addr), 64'd1);
    @(negedge clk);
    check_val("short_pulse_end", 64'(short_frame), 64'd0);
    wait_writes();
    swap_check();
    check_val("short_count", 64'(short_cnt), 64'd1);

    // frame_end coinciding with the final grant
    gnt_mode = 2;
    gnt_manual = 1'b0;
    @(posedge clk); #1;
    rand_frame($urandom_range(1, 8));
    send_frame(1'b1);
    @(negedge clk);
    gnt_manual = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    gnt_manual = 1'b0;
    exp_bank  = !exp_bank;
    exp_count = exp_count + 8'd1;
    @(negedge clk);
    check_val("sim_ready", 64'(pix.s_ready), 64'd1);
    check_val("sim_bank", 64'(mem.mem_bank), 64'(exp_bank));
    check_val("sim_disp", 64'(disp_bank), 64'(!exp_bank));
    check_val("sim_count", 64'(frame_count), 64'(exp_count));
    repeat (3) @(negedge clk);
    check_val("sim_count_hold", 64'(frame_count), 64'(exp_count));
    wait_writes();
    check_val("sim_short_count", 64'(short_cnt), 64'(exp_short));

    // full frame of 4096 pixels, no s_last, random grant
    do_reset();
    gnt_mode = 1;
    idle_en = 1;
    frame_px.delete();
    for (int i = 0; i < 4096; i++) frame_px.push_back(4'hA);
    send_frame(1'b0);
    wait_writes();
    swap_check();
    check_val("full_no_short", 64'(short_cnt), 64'd0);
    rand_frame(8);
    send_frame(1'b0);
    wait_writes();

    // random frames with an ignored frame_end while filling
    do_reset();
    for (int f = 0; f < 6; f++) begin
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
      rand_frame($urandom_range(1, 300));
      send_frame(1'b1);
      wait_writes();
      swap_check();
    end
    check_val("rand_short_count", 64'(short_cnt), 64'(exp_short));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
